i2c_master_seq: RTL and testbench
=================================

// Module: i2c_master_seq
// PURPOSE
//  Transaction sequencer for the I2C master SDA datapath. Accepts one register-style request:
//  7-bit device address, R/W bit, 8-bit memory/register index and 8-bit write data.
//  Drives state[2:0], addr, data and rw into the SDA bit logic, one sda_clk per bit.
//  Samples slave ACKs and read data from sda_in; reports done, NACK error and read data.
// PARAMETERS
//  STOP_HOLD  1  sda_clk cycles spent in STOP before returning to IDLE (>=1)
//  IDLE_GAP   1  minimum IDLE cycles between transactions (>=1); the SDA logic latches addr/rw in IDLE
// PORTS
//  sda_clk    in   1  bit clock; all logic on posedge
//  reset      in   1  asynchronous, active-high
//  req        in   1  transaction request; level, sampled in IDLE only
//  req_addr   in   7  device address
//  req_rw     in   1  0=write, 1=read
//  req_mem    in   8  memory/register index byte
//  req_wdata  in   8  write data byte (ignored on read)
//  req_ready  out  1  1-cycle pulse: request accepted
//  busy       out  1  high from accept until return to IDLE
//  done       out  1  1-cycle pulse on STOP->IDLE
//  nack_err   out  1  valid with done: slave NACK on address or mem byte
//  rd_data    out  8  read byte; held until next accepted read
//  rd_valid   out  1  pulse with done on a read with nack_err=0
//  sda_in     in   1  sampled SDA line (pulled up, 1 when released)
//  scl_en     out  1  high in ADDR..DATA states (SCL gating for the clock block)
//  state      out  3  to SDA logic: 0 IDLE,1 START,2 ADDR,3 RW,4 ACK,5 MEM,6 DATA,7 STOP
//  addr       out  7  to SDA logic; latched req_addr
//  rw         out  1  to SDA logic; latched req_rw
//  data       out  8  to SDA logic; req_mem while ack_idx=0, else req_wdata (latched copies)
// BEHAVIOUR
//  Reset: state=IDLE, addr/data/rw/rd_data=0, all strobes and busy/nack_err/scl_en=0, counters cleared.
//  IDLE: accept when req=1 and gap counter >= IDLE_GAP. Latch all request fields, pulse req_ready, set busy.
//   Next state: START. The request is latched before START; the SDA logic captures addr/rw during that IDLE cycle.
//  START: 1 cycle -> ADDR (bit_cnt=6).
//  ADDR: 7 cycles; bit_cnt 6..0 -> RW. RW: 1 cycle -> ACK (ack_idx=0).
//  ACK: 1 cycle; sda_in sampled on the edge leaving ACK.
//   ack_idx0: sda_in=1 -> nack_err=1, STOP; else MEM.
//   ack_idx1: same check; else DATA.
//   ack_idx2: sda_in ignored (master NACK on read) -> STOP.
//   ack_idx increments on each exit from ACK.
//  MEM, DATA: 8 cycles each, bit_cnt 7..0, then ACK.
//   DATA with rw=1: shift sda_in MSB-first into rd_shift every cycle; copy to rd_data on exit from the last bit.
//  STOP: STOP_HOLD cycles -> IDLE. done pulses on that transition; rd_valid pulses too if rw=1 and no NACK.
//   busy clears and the gap counter restarts.
//  Write, no NACK, STOP_HOLD=1: 29 non-IDLE cycles. State sequence: 1, 2x7, 3, 4, 5x8, 4, 6x8, 4, 7.
//  req asserted while busy: ignored, no queueing; re-sampled only in IDLE after the gap.
//  req deasserted after accept: no effect, the transaction completes.
//  nack_err is cleared on next accept. rd_data is unchanged by writes and NACKed reads.
//  Reset mid-transaction: immediate IDLE. No done, rd_valid or nack_err is generated.
//  Illegal state encoding: recover to STOP, then IDLE, with done and nack_err=1.
// STRUCTURE
//  Shared package i2c_pkg: state codes (IDLE..STOP) used by both this block and the SDA logic,
//   plus ADDR_W=7 and BYTE_W=8.
//  Single module; one small sub-module i2c_bit_counter is natural:
//   3-bit down counter with load value and a last-bit flag.
// TESTING
//  1 Write 0x50/mem 0x10/data 0xA5, sda_in=0 at all ACKs -> state sequence as above.
//    data=0x10 during ACK0 and 0xA5 during ACK1; done at cycle 29+1; nack_err=0.
//  2 Read 0x68/mem 0x3B, drive 0xC3 on sda_in MSB-first in DATA -> rd_data=0xC3, rd_valid with done.
//  3 Address NACK (sda_in=1 at ACK0) -> ACK then STOP, no MEM; done with nack_err=1 after 11 cycles.
//  4 Hold req=1 continuously -> second req_ready exactly IDLE_GAP IDLE cycles after first done.
//    No accept while busy.
//  5 Assert reset during MEM bit 4 -> next cycle state=0, busy=0, no done.
//    A following request completes normally.
//  6 STOP_HOLD=3 -> 3 cycles of state=7 before IDLE; scl_en low in START, STOP, IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master sequencer and the SDA bit logic.
// The state codes are the on-wire encoding seen by the SDA logic.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_RW    = 3'd3,
    ST_ACK   = 3'd4,
    ST_MEM   = 3'd5,
    ST_DATA  = 3'd6,
    ST_STOP  = 3'd7
  } i2c_state_e;

endpackage

// File: rtl/i2c_master_seq_if.sv
// Request and SDA-side bus of the I2C master sequencer.
// Handshake: a request is taken in the cycle where req and req_ready are both high;
// req_ready only ever rises while the sequencer is idle, so req may stay high or drop afterwards.
interface i2c_master_seq_if;
  import i2c_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic [BYTE_W-1:0] req_mem;
  logic [BYTE_W-1:0] req_wdata;
  logic              req_ready;
  logic              busy;
  logic              done;
  logic              nack_err;
  logic [BYTE_W-1:0] rd_data;
  logic              rd_valid;
  logic              sda_in;
  logic              scl_en;
  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [BYTE_W-1:0] data;

  modport master (
    input  req, req_addr, req_rw, req_mem, req_wdata, sda_in,
    output req_ready, busy, done, nack_err, rd_data, rd_valid,
           scl_en, state, addr, rw, data
  );

  modport slave (
    output req, req_addr, req_rw, req_mem, req_wdata, sda_in,
    input  req_ready, busy, done, nack_err, rd_data, rd_valid,
           scl_en, state, addr, rw, data
  );

endinterface

// File: rtl/i2c_bit_counter.sv
// 3-bit down counter for bit positions inside ADDR/MEM/DATA; last flags bit 0.
module i2c_bit_counter (
  input  logic       sda_clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       en,
  output logic [2:0] cnt,
  output logic       last
);

  always_ff @(posedge sda_clk or posedge reset) begin
    if (reset)     cnt <= 3'd0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt - 3'd1;
  end

  assign last = (cnt == 3'd0);

endmodule

// File: rtl/i2c_master_seq.sv
// Transaction sequencer for the I2C master SDA datapath: walks one register-style
// request through START/ADDR/RW/ACK/MEM/DATA/STOP and collects ACKs and read data.
module i2c_master_seq
  import i2c_pkg::*;
#(
  parameter int STOP_HOLD = 1,
  parameter int IDLE_GAP  = 1
) (
  input logic          sda_clk,
  input logic          reset,
  i2c_master_seq_if.master bus
);

  i2c_state_e        st_q, st_d;
  logic              accept, nack_set, illegal;
  logic              bc_load, bc_en, bit_last;
  logic [2:0]        bc_val, bit_cnt;
  logic [1:0]        ack_idx;
  logic [7:0]        gap_cnt, stop_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [BYTE_W-1:0] mem_q, wdata_q, rd_data_q;
  logic [6:0]        rd_shift;
  logic              busy_q, done_q, nack_q, rd_valid_q;

  assign accept = (st_q == ST_IDLE) && bus.req && (gap_cnt >= 8'(IDLE_GAP));

  i2c_bit_counter u_bit_cnt (
    .sda_clk  (sda_clk),
    .reset    (reset),
    .load     (bc_load),
    .load_val (bc_val),
    .en       (bc_en),
    .cnt      (bit_cnt),
    .last     (bit_last)
  );

  always_ff @(posedge sda_clk or posedge reset) begin
    if (reset) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d     = st_q;
    bc_load  = 1'b0;
    bc_val   = 3'd7;
    bc_en    = 1'b0;
    nack_set = 1'b0;
    illegal  = 1'b0;
    case (st_q)
      ST_IDLE:  if (accept) st_d = ST_START;
      ST_START: begin
        st_d    = ST_ADDR;
        bc_load = 1'b1;
        bc_val  = 3'd6;
      end
      ST_ADDR: begin
        bc_en = 1'b1;
        if (bit_last) st_d = ST_RW;
      end
      ST_RW:    st_d = ST_ACK;
      ST_ACK: begin
        // The third ACK slot is the master's own NACK after the read byte.
        if (ack_idx >= 2'd2) begin
          st_d = ST_STOP;
        end else if (bus.sda_in) begin
          nack_set = 1'b1;
          st_d     = ST_STOP;
        end else begin
          st_d    = (ack_idx == 2'd0) ? ST_MEM : ST_DATA;
          bc_load = 1'b1;
          bc_val  = 3'd7;
        end
      end
      ST_MEM, ST_DATA: begin
        bc_en = 1'b1;
        if (bit_last) st_d = ST_ACK;
      end
      ST_STOP:  if (stop_cnt == 8'(STOP_HOLD - 1)) st_d = ST_IDLE;
      default: begin
        st_d    = ST_STOP;
        illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sda_clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      rw_q       <= 1'b0;
      mem_q      <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_shift   <= '0;
      ack_idx    <= 2'd0;
      gap_cnt    <= 8'd0;
      stop_cnt   <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      if (accept) begin
        addr_q  <= bus.req_addr;
        rw_q    <= bus.req_rw;
        mem_q   <= bus.req_mem;
        wdata_q <= bus.req_wdata;
        ack_idx <= 2'd0;
        nack_q  <= 1'b0;
        busy_q  <= 1'b1;
      end
      if (st_q == ST_ACK) ack_idx <= ack_idx + 2'd1;
      if (nack_set || illegal) nack_q <= 1'b1;
      if (st_q == ST_DATA && rw_q) begin
        rd_shift <= {rd_shift[5:0], bus.sda_in};
        if (bit_last) rd_data_q <= {rd_shift, bus.sda_in};
      end
      stop_cnt <= (st_q == ST_STOP) ? stop_cnt + 8'd1 : 8'd0;
      // Gap restarts whenever a transaction is in flight and saturates at IDLE_GAP.
      if (st_q != ST_IDLE)             gap_cnt <= 8'd0;
      else if (gap_cnt < 8'(IDLE_GAP)) gap_cnt <= gap_cnt + 8'd1;
      if (st_q == ST_STOP && st_d == ST_IDLE) begin
        done_q     <= 1'b1;
        rd_valid_q <= rw_q && !nack_q;
        busy_q     <= 1'b0;
      end
    end
  end

  assign bus.req_ready = accept;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.nack_err  = nack_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.scl_en    = (st_q >= ST_ADDR) && (st_q <= ST_DATA);
  assign bus.state     = st_q;
  assign bus.addr      = addr_q;
  assign bus.rw        = rw_q;
  assign bus.data      = (ack_idx == 2'd0) ? mem_q : wdata_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: two instances (STOP_HOLD 1 and 3) share stimulus,
// a per-transaction expected state queue is built from the protocol rules.
module tb_i2c_master_seq;
  import i2c_pkg::*;

  localparam int GAP = 1;

  logic sda_clk = 1'b0;
  logic reset;
  always #5 sda_clk = ~sda_clk;

  i2c_master_seq_if bus1 ();
  i2c_master_seq_if bus3 ();

  i2c_master_seq #(.STOP_HOLD(1), .IDLE_GAP(GAP)) u_dut (
    .sda_clk (sda_clk),
    .reset   (reset),
    .bus     (bus1.master)
  );

  i2c_master_seq #(.STOP_HOLD(3), .IDLE_GAP(GAP)) u_dut3 (
    .sda_clk (sda_clk),
    .reset   (reset),
    .bus     (bus3.master)
  );

  logic       sel, req, r_rw, sda_in;
  logic [6:0] r_addr;
  logic [7:0] r_mem, r_wdata;

  assign bus1.req = req && !sel;
  assign bus3.req = req && sel;
  assign bus1.req_addr = r_addr;
  assign bus3.req_addr = r_addr;
  assign bus1.req_rw = r_rw;
  assign bus3.req_rw = r_rw;
  assign bus1.req_mem = r_mem;
  assign bus3.req_mem = r_mem;
  assign bus1.req_wdata = r_wdata;
  assign bus3.req_wdata = r_wdata;
  assign bus1.sda_in = sda_in;
  assign bus3.sda_in = sda_in;

  wire [2:0] o_state = sel ? bus3.state : bus1.state;
  wire [6:0] o_addr = sel ? bus3.addr : bus1.addr;
  wire [7:0] o_data = sel ? bus3.data : bus1.data;
  wire [7:0] o_rd_data = sel ? bus3.rd_data : bus1.rd_data;
  wire       o_rw = sel ? bus3.rw : bus1.rw;
  wire       o_req_ready = sel ? bus3.req_ready : bus1.req_ready;
  wire       o_busy = sel ? bus3.busy : bus1.busy;
  wire       o_done = sel ? bus3.done : bus1.done;
  wire       o_nack = sel ? bus3.nack_err : bus1.nack_err;
  wire       o_rd_valid = sel ? bus3.rd_valid : bus1.rd_valid;
  wire       o_scl_en = sel ? bus3.scl_en : bus1.scl_en;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];
  logic [7:0] model_rd[2];

  task automatic tick;
    @(negedge sda_clk);
    #1;
  endtask

  // Expected non-IDLE state trace from the protocol rules; nack_at is the failing ACK slot or -1.
  function automatic void build_seq(input int nack_at, input int stop_hold);
    exp_q.delete();
    exp_q.push_back(3'd1);
    repeat (7) exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    if (nack_at != 0) begin
      repeat (8) exp_q.push_back(3'd5);
      exp_q.push_back(3'd4);
      if (nack_at != 1) begin
        repeat (8) exp_q.push_back(3'd6);
        exp_q.push_back(3'd4);
      end
    end
    repeat (stop_hold) exp_q.push_back(3'd7);
  endfunction

  task automatic run_txn(input logic [6:0] a, input logic rwb, input logic [7:0] m,
                         input logic [7:0] w, input logic [7:0] rdb, input int nack_at,
                         input bit hold, input int abort_at);
    int ackn, dbit, i, k;
    logic [2:0] exp_s;
    logic [3:0] exp_flags;
    build_seq(nack_at, sel ? 3 : 1);
    r_addr = a; r_rw = rwb; r_mem = m; r_wdata = w;
    req = 1'b1; sda_in = 1'b1;
    #1;
    for (k = 0; k < 50 && !o_req_ready; k++) tick();
    n_checks++;
    if (o_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL accept_timeout: req_ready=%b want 1 within 50 cycles", o_req_ready);
      req = 1'b0;
      return;
    end
    ackn = 0; dbit = 0; i = 0;
    while (exp_q.size() > 0) begin
      tick();
      req = hold;
      exp_s = exp_q.pop_front();
      n_checks++;
      if (o_state !== exp_s) begin
        n_errors++;
        $display("FAIL state[%0d]: got %0d want %0d", i, o_state, exp_s);
      end
      exp_flags = {1'b1, 1'b0, 1'b0, (exp_s >= 3'd2 && exp_s <= 3'd6)};
      n_checks++;
      if ({o_busy, o_done, o_req_ready, o_scl_en} !== exp_flags) begin
        n_errors++;
        $display("FAIL flags[%0d] busy/done/ready/scl: got %b want %b", i,
                 {o_busy, o_done, o_req_ready, o_scl_en}, exp_flags);
      end
      n_checks++;
      if ({o_addr, o_rw} !== {a, rwb}) begin
        n_errors++;
        $display("FAIL addr_rw[%0d]: got %h/%b want %h/%b", i, o_addr, o_rw, a, rwb);
      end
      if (i == 0) begin
        n_checks++;
        if (o_nack !== 1'b0) begin
          n_errors++;
          $display("FAIL nack_clear: got %b want 0", o_nack);
        end
      end
      if (i == abort_at) begin
        reset = 1'b1;
        tick();
        n_checks++;
        if ({o_state, o_busy, o_done, o_scl_en} !== 6'd0) begin
          n_errors++;
          $display("FAIL reset_abort: state/busy/done/scl got %b want 000000",
                   {o_state, o_busy, o_done, o_scl_en});
        end
        reset = 1'b0;
        req = 1'b0;
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
        tick();
        n_checks++;
        if ({o_done, o_nack, o_rd_valid, o_rd_data} !== 11'd0) begin
          n_errors++;
          $display("FAIL reset_quiet: done/nack/rd_valid/rd_data got %b want 0",
                   {o_done, o_nack, o_rd_valid, o_rd_data});
        end
        exp_q.delete();
        return;
      end
      if (exp_s == 3'd4) begin
        n_checks++;
        if (o_data !== ((ackn == 0) ? m : w)) begin
          n_errors++;
          $display("FAIL data_ack%0d: got %h want %h", ackn, o_data, (ackn == 0) ? m : w);
        end
        sda_in = (ackn == nack_at) || (ackn == 2);
        ackn++;
      end else if (exp_s == 3'd6 && rwb) begin
        sda_in = rdb[7 - dbit];
        dbit++;
      end else begin
        sda_in = 1'b1;
      end
      i++;
    end
    tick();
    sda_in = 1'b1;
    if (rwb && nack_at < 0) model_rd[sel] = rdb;
    n_checks++;
    if ({o_state, o_busy, o_done, o_req_ready, o_scl_en} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL done_cycle: state/busy/done/ready/scl got %b want 0000100",
               {o_state, o_busy, o_done, o_req_ready, o_scl_en});
    end
    n_checks++;
    if ({o_nack, o_rd_valid} !== {(nack_at >= 0), (rwb && nack_at < 0)}) begin
      n_errors++;
      $display("FAIL status: nack/rd_valid got %b%b want %b%b", o_nack, o_rd_valid,
               (nack_at >= 0), (rwb && nack_at < 0));
    end
    n_checks++;
    if (o_rd_data !== model_rd[sel]) begin
      n_errors++;
      $display("FAIL rd_data: got %h want %h", o_rd_data, model_rd[sel]);
    end
    if (!hold) req = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({o_state, o_addr, o_rw, o_data, o_rd_data} !== 27'd0) begin
      n_errors++;
      $display("FAIL reset_regs: got %h want 0", {o_state, o_addr, o_rw, o_data, o_rd_data});
    end
    n_checks++;
    if ({o_busy, o_done, o_nack, o_rd_valid, o_scl_en, o_req_ready} !== 6'd0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {o_busy, o_done, o_nack, o_rd_valid, o_scl_en, o_req_ready});
    end
  endtask

  task automatic test_write;
    sel = 1'b0;
    run_txn(7'h50, 1'b0, 8'h10, 8'hA5, 8'h00, -1, 1'b0, -1);
  endtask

  task automatic test_read;
    sel = 1'b0;
    run_txn(7'h68, 1'b1, 8'h3B, 8'h00, 8'hC3, -1, 1'b0, -1);
    tick();
    run_txn(7'h22, 1'b0, 8'h01, 8'h5A, 8'h00, -1, 1'b0, -1);
  endtask

  task automatic test_addr_nack;
    sel = 1'b0;
    run_txn(7'h11, 1'b1, 8'h44, 8'h00, 8'hFF, 0, 1'b0, -1);
    run_txn(7'h12, 1'b0, 8'h45, 8'h99, 8'h00, 1, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    run_txn(7'h33, 1'b0, 8'h20, 8'h7E, 8'h00, -1, 1'b1, -1);
    for (int g = 1; g <= GAP; g++) begin
      tick();
      n_checks++;
      if (o_req_ready !== (g == GAP)) begin
        n_errors++;
        $display("FAIL gap_ready[%0d]: got %b want %b", g, o_req_ready, (g == GAP));
      end
    end
    run_txn(7'h33, 1'b0, 8'h20, 8'h7E, 8'h00, -1, 1'b0, -1);
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    run_txn(7'h5C, 1'b0, 8'h81, 8'h18, 8'h00, -1, 1'b0, 13);
    run_txn(7'h5C, 1'b1, 8'h81, 8'h00, 8'h96, -1, 1'b0, -1);
  endtask

  task automatic test_stop_hold;
    sel = 1'b1;
    run_txn(7'h0F, 1'b0, 8'hE0, 8'h3C, 8'h00, -1, 1'b0, -1);
    run_txn(7'h70, 1'b1, 8'h07, 8'h00, 8'h6D, -1, 1'b0, -1);
    sel = 1'b0;
  endtask

  task automatic test_random;
    int na;
    for (int t = 0; t < 14; t++) begin
      sel = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        2:       na = 0;
        3:       na = 1;
        default: na = -1;
      endcase
      run_txn(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), na, 1'b0, -1);
      repeat ($urandom_range(0, 3)) tick();
    end
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0; sda_in = 1'b1; sel = 1'b0;
    r_addr = '0; r_rw = 1'b0; r_mem = '0; r_wdata = '0;
    model_rd[0] = 8'h00;
    model_rd[1] = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_back_to_back();
    test_reset_mid();
    test_stop_hold();
    test_random();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
